// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage: IF/ID register, 32x32 register file,
// decoder, branch resolution in ID and the registered ID/EXE bundle.
module id_stage #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_instruction,
   input  logic [31:0] if_pc,
   input  logic        freeze,
   input  logic        wb_en,
   input  logic [4:0]  wb_dest,
   input  logic [31:0] wb_value,
   output logic        branch_taken,
   output logic [31:0] branch_address,
   output logic [3:0]  ex_cmd,
   output logic [31:0] ex_val1,
   output logic [31:0] ex_val2,
   output logic [31:0] ex_st_val,
   output logic [4:0]  ex_dest,
   output logic        ex_wb_en,
   output logic        ex_mem_r_en,
   output logic        ex_mem_w_en,
   output logic [31:0] ex_pc
);

   localparam logic [5:0] OP_ADD  = 6'b000001, OP_SUB  = 6'b000011, OP_AND  = 6'b000101,
                          OP_OR   = 6'b000110, OP_NOR  = 6'b000111, OP_XOR  = 6'b001000,
                          OP_SLA  = 6'b001001, OP_SLL  = 6'b001010, OP_SRA  = 6'b001011,
                          OP_SRL  = 6'b001100, OP_ADDI = 6'b100000, OP_SUBI = 6'b100001,
                          OP_LD   = 6'b100100, OP_ST   = 6'b100101, OP_BEZ  = 6'b101000,
                          OP_BNE  = 6'b101001, OP_JMP  = 6'b101010;

   localparam logic [3:0] CMD_ADD = 4'b0000, CMD_SUB = 4'b0010, CMD_AND = 4'b0100,
                          CMD_OR  = 4'b0101, CMD_NOR = 4'b0110, CMD_XOR = 4'b0111,
                          CMD_SLA = 4'b1000, CMD_SLL = 4'b1001, CMD_SRA = 4'b1010,
                          CMD_SRL = 4'b1011;

   logic [31:0] id_ir;
   logic [31:0] id_pc;
   logic [31:0] rf [32];

   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext;
   logic [31:0] rs_val, rt_val;

   logic [3:0]  d_cmd;
   logic [4:0]  d_dest;
   logic        d_wb, d_mr, d_mw, use_imm, is_br, br_cond;
   logic [31:0] target;

   assign op       = id_ir[31:26];
   assign rs       = id_ir[25:21];
   assign rt       = id_ir[20:16];
   assign rd       = id_ir[15:11];
   assign imm_sext = {{16{id_ir[15]}}, id_ir[15:0]};

   // Register file: contents survive reset; r0 is never stored to and reads as zero.
   always_ff @(posedge clk) begin
      if (wb_en && wb_dest != 5'd0)
         rf[wb_dest] <= wb_value;
   end

   // Write-through: a same-cycle WB to the read index is returned directly.
   always_comb begin
      rs_val = rf[rs];
      if (rs == 5'd0)
         rs_val = 32'd0;
      else if (wb_en && wb_dest == rs)
         rs_val = wb_value;
      rt_val = rf[rt];
      if (rt == 5'd0)
         rt_val = 32'd0;
      else if (wb_en && wb_dest == rt)
         rt_val = wb_value;
   end

   always_comb begin
      d_cmd   = CMD_ADD;
      d_dest  = 5'd0;
      d_wb    = 1'b0;
      d_mr    = 1'b0;
      d_mw    = 1'b0;
      use_imm = 1'b0;
      is_br   = 1'b0;
      br_cond = 1'b0;
      case (op)
         OP_ADD:  begin d_cmd = CMD_ADD; d_dest = rd; d_wb = 1'b1; end
         OP_SUB:  begin d_cmd = CMD_SUB; d_dest = rd; d_wb = 1'b1; end
         OP_AND:  begin d_cmd = CMD_AND; d_dest = rd; d_wb = 1'b1; end
         OP_OR:   begin d_cmd = CMD_OR;  d_dest = rd; d_wb = 1'b1; end
         OP_NOR:  begin d_cmd = CMD_NOR; d_dest = rd; d_wb = 1'b1; end
         OP_XOR:  begin d_cmd = CMD_XOR; d_dest = rd; d_wb = 1'b1; end
         OP_SLA:  begin d_cmd = CMD_SLA; d_dest = rd; d_wb = 1'b1; end
         OP_SLL:  begin d_cmd = CMD_SLL; d_dest = rd; d_wb = 1'b1; end
         OP_SRA:  begin d_cmd = CMD_SRA; d_dest = rd; d_wb = 1'b1; end
         OP_SRL:  begin d_cmd = CMD_SRL; d_dest = rd; d_wb = 1'b1; end
         OP_ADDI: begin d_cmd = CMD_ADD; d_dest = rt; d_wb = 1'b1; use_imm = 1'b1; end
         OP_SUBI: begin d_cmd = CMD_SUB; d_dest = rt; d_wb = 1'b1; use_imm = 1'b1; end
         OP_LD:   begin d_cmd = CMD_ADD; d_dest = rt; d_wb = 1'b1; d_mr = 1'b1; use_imm = 1'b1; end
         OP_ST:   begin d_cmd = CMD_ADD; d_mw = 1'b1; use_imm = 1'b1; end
         OP_BEZ:  begin is_br = 1'b1; br_cond = (rs_val == 32'd0); end
         OP_BNE:  begin is_br = 1'b1; br_cond = (rs_val != rt_val); end
         OP_JMP:  begin is_br = 1'b1; br_cond = 1'b1; end
         default: ;
      endcase
      if (d_dest == 5'd0)
         d_wb = 1'b0;
   end

   assign target         = id_pc + 32'd4 + {imm_sext[29:0], 2'b00};
   assign branch_taken   = is_br & br_cond & ~freeze & ~rst;
   assign branch_address = is_br ? target : 32'd0;

   // A taken redirect squashes the word fetched behind the branch at the same edge.
   always_ff @(posedge clk) begin
      if (rst || branch_taken) begin
         id_ir <= NOP_WORD;
         id_pc <= 32'd0;
      end else if (!freeze) begin
         id_ir <= if_instruction;
         id_pc <= if_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (!freeze && is_br)) begin
         ex_cmd      <= 4'd0;
         ex_val1     <= 32'd0;
         ex_val2     <= 32'd0;
         ex_st_val   <= 32'd0;
         ex_dest     <= 5'd0;
         ex_wb_en    <= 1'b0;
         ex_mem_r_en <= 1'b0;
         ex_mem_w_en <= 1'b0;
         ex_pc       <= 32'd0;
      end else if (!freeze) begin
         ex_cmd      <= d_cmd;
         ex_val1     <= rs_val;
         ex_val2     <= use_imm ? imm_sext : rt_val;
         ex_st_val   <= rt_val;
         ex_dest     <= d_dest;
         ex_wb_en    <= d_wb;
         ex_mem_r_en <= d_mr;
         ex_mem_w_en <= d_mw;
         ex_pc       <= id_pc;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed-vector bench for id_stage.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_instruction, if_pc;
   logic        freeze;
   logic        wb_en;
   logic [4:0]  wb_dest;
   logic [31:0] wb_value;
   logic        branch_taken;
   logic [31:0] branch_address;
   logic [3:0]  ex_cmd;
   logic [31:0] ex_val1, ex_val2, ex_st_val, ex_pc;
   logic [4:0]  ex_dest;
   logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst), .if_instruction(if_instruction), .if_pc(if_pc),
      .freeze(freeze), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .branch_taken(branch_taken), .branch_address(branch_address),
      .ex_cmd(ex_cmd), .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_st_val(ex_st_val),
      .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
      .ex_mem_w_en(ex_mem_w_en), .ex_pc(ex_pc)
   );

   localparam logic [31:0] NOP = 32'h0;

   function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
      if_instruction = ins;
      if_pc = pc;
      tick();
      if_instruction = NOP;
      if_pc = 32'd0;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] val);
      wb_en = 1'b1;
      wb_dest = idx;
      wb_value = val;
      tick();
      wb_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; wb_en = 1'b0; wb_dest = 5'd0; wb_value = 32'd0;
      if_instruction = NOP; if_pc = 32'd0;

      // 1. reset, then ADDI r1,r0,1546
      tick(); tick();
      chk("rst_cmd", ex_cmd, 0);
      chk("rst_val1", ex_val1, 0);
      chk("rst_val2", ex_val2, 0);
      chk("rst_st_val", ex_st_val, 0);
      chk("rst_dest", ex_dest, 0);
      chk("rst_wb", ex_wb_en, 0);
      chk("rst_mr", ex_mem_r_en, 0);
      chk("rst_mw", ex_mem_w_en, 0);
      chk("rst_pc", ex_pc, 0);
      chk("rst_taken", branch_taken, 0);
      rst = 1'b0;
      feed(i_ins(6'b100000, 5'd0, 5'd1, 16'd1546), 32'd4);
      feed(NOP, 32'd8);
      chk("addi_cmd", ex_cmd, 4'b0000);
      chk("addi_val2", ex_val2, 32'd1546);
      chk("addi_dest", ex_dest, 5'd1);
      chk("addi_wb", ex_wb_en, 1);
      chk("addi_pc", ex_pc, 32'd4);

      // 2. SUB / ST with register contents, then write-through bypass
      wr(5'd1, 32'd1546);
      wr(5'd2, 32'd1546);
      wr(5'd3, 32'hFFFF_F9F6);
      feed(r_ins(6'b000011, 5'd0, 5'd1, 5'd3), 32'd8);
      feed(i_ins(6'b100101, 5'd1, 5'd2, 16'd0), 32'd12);
      chk("sub_cmd", ex_cmd, 4'b0010);
      chk("sub_val2", ex_val2, 32'd1546);
      chk("sub_dest", ex_dest, 5'd3);
      chk("sub_wb", ex_wb_en, 1);
      feed(NOP, 32'd16);
      chk("st_mw", ex_mem_w_en, 1);
      chk("st_wb", ex_wb_en, 0);
      chk("st_val", ex_st_val, 32'd1546);
      chk("st_val1", ex_val1, 32'd1546);
      chk("st_val2", ex_val2, 32'd0);
      feed(r_ins(6'b000001, 5'd5, 5'd0, 5'd6), 32'd20);
      wb_en = 1'b1; wb_dest = 5'd5; wb_value = 32'h1234_5678;
      tick();
      wb_en = 1'b0;
      chk("bypass_val1", ex_val1, 32'h1234_5678);
      feed(r_ins(6'b000001, 5'd5, 5'd0, 5'd6), 32'd24);
      feed(NOP, 32'd28);
      chk("r5_readback", ex_val1, 32'h1234_5678);

      // 3. BNE taken / not taken, squash of the word behind it
      wr(5'd1, 32'd3);
      wr(5'd3, 32'd2);
      feed(i_ins(6'b101001, 5'd1, 5'd3, 16'hFFE1), 32'd316);
      chk("bne_taken", branch_taken, 1);
      chk("bne_addr", branch_address, 32'd196);
      feed(i_ins(6'b100000, 5'd0, 5'd7, 16'd5), 32'd320);
      chk("bne_bubble_wb", ex_wb_en, 0);
      chk("bne_bubble_cmd", ex_cmd, 0);
      chk("bne_bubble_pc", ex_pc, 0);
      chk("after_bne_taken", branch_taken, 0);
      feed(NOP, 32'd196);
      chk("squash_dest", ex_dest, 0);
      chk("squash_wb", ex_wb_en, 0);
      chk("squash_pc", ex_pc, 0);
      wr(5'd3, 32'd3);
      feed(i_ins(6'b101001, 5'd1, 5'd3, 16'hFFE1), 32'd316);
      chk("bne_eq_taken", branch_taken, 0);
      chk("bne_eq_addr", branch_address, 32'd196);

      // 4. JMP -1 on every decode, BEZ not taken
      feed(i_ins(6'b101010, 5'd0, 5'd0, 16'hFFFF), 32'd396);
      chk("jmp_taken", branch_taken, 1);
      chk("jmp_addr", branch_address, 32'd396);
      feed(i_ins(6'b101010, 5'd0, 5'd0, 16'hFFFF), 32'd396);
      chk("jmp_squashed", branch_taken, 0);
      feed(i_ins(6'b101010, 5'd0, 5'd0, 16'hFFFF), 32'd396);
      chk("jmp2_taken", branch_taken, 1);
      chk("jmp2_addr", branch_address, 32'd396);
      feed(NOP, 32'd0);
      wr(5'd5, 32'd1546);
      feed(i_ins(6'b101000, 5'd5, 5'd0, 16'd1), 32'd400);
      chk("bez_nt_taken", branch_taken, 0);
      chk("bez_nt_addr", branch_address, 32'd408);

      // 5. XOR into r0, and r0 stays zero under WB
      wr(5'd1, 32'h0000_00FF);
      feed(r_ins(6'b001000, 5'd5, 5'd1, 5'd0), 32'd404);
      feed(r_ins(6'b000001, 5'd0, 5'd0, 5'd6), 32'd408);
      chk("xor_cmd", ex_cmd, 4'b0111);
      chk("xor_wb", ex_wb_en, 0);
      chk("xor_dest", ex_dest, 0);
      wb_en = 1'b1; wb_dest = 5'd0; wb_value = 32'hDEAD_BEEF;
      tick();
      wb_en = 1'b0;
      chk("r0_bypass_val1", ex_val1, 0);
      chk("r0_bypass_val2", ex_val2, 0);
      feed(r_ins(6'b000001, 5'd0, 5'd0, 5'd6), 32'd412);
      feed(NOP, 32'd416);
      chk("r0_read", ex_val1, 0);

      // 6. freeze during a taken BEZ, then reset during a taken BEZ
      wr(5'd5, 32'd0);
      feed(i_ins(6'b100000, 5'd0, 5'd7, 16'd77), 32'd496);
      feed(i_ins(6'b101000, 5'd5, 5'd0, 16'd2), 32'd500);
      chk("bez_taken", branch_taken, 1);
      chk("bez_addr", branch_address, 32'd512);
      freeze = 1'b1;
      if_instruction = i_ins(6'b100000, 5'd0, 5'd8, 16'd9);
      if_pc = 32'd504;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("frz_taken", branch_taken, 0);
         tick();
         chk("frz_dest", ex_dest, 5'd7);
         chk("frz_pc", ex_pc, 32'd496);
      end
      freeze = 1'b0;
      #1;
      chk("unfrz_taken", branch_taken, 1);
      chk("unfrz_addr", branch_address, 32'd512);
      feed(i_ins(6'b100000, 5'd0, 5'd8, 16'd9), 32'd504);
      chk("fire_once", branch_taken, 0);
      chk("unfrz_bubble_pc", ex_pc, 0);
      feed(i_ins(6'b101000, 5'd5, 5'd0, 16'd2), 32'd500);
      chk("bez2_taken", branch_taken, 1);
      rst = 1'b1;
      if_instruction = i_ins(6'b100000, 5'd0, 5'd8, 16'd9);
      if_pc = 32'd504;
      #1;
      chk("rst_drop_taken", branch_taken, 0);
      tick();
      rst = 1'b0;
      chk("rst_mid_dest", ex_dest, 0);
      chk("rst_mid_taken", branch_taken, 0);
      feed(NOP, 32'd0);
      chk("rst_mid_ifid_dest", ex_dest, 0);
      chk("rst_mid_ifid_wb", ex_wb_en, 0);
      chk("rst_mid_ifid_pc", ex_pc, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
